// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite SRAM slave: single-port word memory with byte-lane writes,
// optional wait states on OKAY transfers and a two-cycle ERROR response.
//
// Ports:
//   HCLK, HRESETn        bus clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS  address-phase select / byte address / transfer type
//   HWRITE, HSIZE        direction and size (byte, halfword, word)
//   HBURST, HPROT,       accepted but unused
//   HMASTLOCK
//   HWDATA               write data, sampled on the completing edge
//   HREADY               bus-wide ready (ends the previous data phase)
//   HRDATA               read data, valid while HREADYOUT=1 completes a read
//   HREADYOUT, HRESP     this slave's ready and response (1 = ERROR)
module ahb3lite_sram_slave #(
    parameter int unsigned HADDR_SIZE  = 16,
    parameter int unsigned HDATA_SIZE  = 32,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HMASTLOCK,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    state_t          state;
    logic [CW-1:0]   wait_cnt;

    // Pending OKAY data phase captured from the accepted address phase
    logic            dp_active;
    logic            dp_write;
    logic [AW-1:0]   dp_word;
    logic [3:0]      dp_lanes;

    logic [31:0]     mem [MEM_DEPTH];

    logic            accept;
    logic            addr_err;
    logic            addr_oor;
    logic [3:0]      addr_lanes;
    logic [AW-1:0]   addr_word;
    logic            wr_fire;
    logic [31:0]     rd_word;

    logic            unused_ok;
    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

    // Replace enabled byte lanes of old_w with new_w
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
        end
        return res;
    endfunction

    // Address-phase decode
    assign addr_word = HADDR[AW+1:2];

    generate
        if (HADDR_SIZE > AW + 2) begin : g_oor
            assign addr_oor = |HADDR[HADDR_SIZE-1:AW+2];
        end else begin : g_no_oor
            assign addr_oor = 1'b0;
        end
    endgenerate

    always_comb begin
        addr_lanes = 4'b0000;
        case (HSIZE)
            3'd0:    addr_lanes = 4'b0001 << HADDR[1:0];
            3'd1:    addr_lanes = HADDR[1] ? 4'b1100 : 4'b0011;
            3'd2:    addr_lanes = 4'b1111;
            default: addr_lanes = 4'b0000;
        endcase
    end

    assign addr_err = (HSIZE > 3'd2)
                    | ((HSIZE == 3'd1) & HADDR[0])
                    | ((HSIZE == 3'd2) & (|HADDR[1:0]))
                    | addr_oor;

    // ERR1 never accepts; HREADY is low there anyway, the state gate makes it explicit
    assign accept = HSEL & HREADY & HTRANS[1]
                  & ((state == ST_IDLE) | (state == ST_ERR2));

    // A write data phase completes on this edge
    assign wr_fire = dp_active & dp_write & HREADYOUT & (state == ST_IDLE);

    // Zero-wait read of the word being written on this same edge sees the new lanes
    assign rd_word = (wr_fire && (dp_word == addr_word))
                   ? merge_lanes(mem[addr_word], HWDATA[31:0], dp_lanes)
                   : mem[addr_word];

    // Memory array, never reset
    always_ff @(posedge HCLK) begin
        if (wr_fire) begin
            mem[dp_word] <= merge_lanes(mem[dp_word], HWDATA[31:0], dp_lanes);
        end
    end

    // Transfer FSM with registered bus outputs
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= '0;
            dp_active <= 1'b0;
            dp_write  <= 1'b0;
            dp_word   <= '0;
            dp_lanes  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_ERR2: begin
                    state     <= ST_IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b0;
                    dp_active <= 1'b0;
                    if (accept) begin
                        if (addr_err) begin
                            state     <= ST_ERR1;
                            HREADYOUT <= 1'b0;
                            HRESP     <= 1'b1;
                        end else begin
                            dp_active <= 1'b1;
                            dp_write  <= HWRITE;
                            dp_word   <= addr_word;
                            dp_lanes  <= addr_lanes;
                            if (WAIT_STATES > 0) begin
                                state     <= ST_WAIT;
                                wait_cnt  <= CW'(WAIT_STATES);
                                HREADYOUT <= 1'b0;
                            end else if (!HWRITE) begin
                                HRDATA <= HDATA_SIZE'(rd_word);
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - CW'(1);
                    // Last wait cycle: load read data for the completing cycle
                    if (wait_cnt <= CW'(1)) begin
                        state     <= ST_IDLE;
                        HREADYOUT <= 1'b1;
                        if (!dp_write) begin
                            HRDATA <= HDATA_SIZE'(mem[dp_word]);
                        end
                    end
                end
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b1;
                    HRDATA    <= '0;
                end
                default: begin
                    state     <= ST_IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Directed bench: one slave with zero wait states, one with three.
module tb_ahb3lite_sram_slave;

    localparam logic [1:0] IDL = 2'd0;
    localparam logic [1:0] BSY = 2'd1;
    localparam logic [1:0] NS  = 2'd2;
    localparam logic [2:0] SB  = 3'd0;
    localparam logic [2:0] SH  = 3'd1;
    localparam logic [2:0] SW  = 3'd2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsel0, hsel3;
    logic [15:0] haddr;
    logic [31:0] hwdata;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic        stall;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hmastlock;

    logic [31:0] hrdata0, hrdata3;
    logic        hreadyout0, hreadyout3;
    logic        hresp0, hresp3;
    logic        hready0, hready3;

    int total = 0;
    int bad   = 0;
    int lows;

    assign hready0 = hreadyout0 & ~stall;
    assign hready3 = hreadyout3 & ~stall;

    always #5 clk = ~clk;

    ahb3lite_sram_slave #(.HADDR_SIZE(16), .HDATA_SIZE(32), .MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel0), .HADDR(haddr), .HWDATA(hwdata),
        .HRDATA(hrdata0), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
        .HTRANS(htrans), .HMASTLOCK(hmastlock), .HREADY(hready0),
        .HREADYOUT(hreadyout0), .HRESP(hresp0)
    );

    ahb3lite_sram_slave #(.HADDR_SIZE(16), .HDATA_SIZE(32), .MEM_DEPTH(256), .WAIT_STATES(3)) dut3 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel3), .HADDR(haddr), .HWDATA(hwdata),
        .HRDATA(hrdata3), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
        .HTRANS(htrans), .HMASTLOCK(hmastlock), .HREADY(hready3),
        .HREADYOUT(hreadyout3), .HRESP(hresp3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rdy(input int d);
        return (d == 3) ? 32'(hreadyout3) : 32'(hreadyout0);
    endfunction

    function automatic logic [31:0] rsp(input int d);
        return (d == 3) ? 32'(hresp3) : 32'(hresp0);
    endfunction

    function automatic logic [31:0] rdat(input int d);
        return (d == 3) ? hrdata3 : hrdata0;
    endfunction

    // Advance one bus cycle, drive it, then stop at the falling edge for checks
    task automatic cyc(input int d, input logic [1:0] tr, input logic wr,
                       input logic [2:0] sz, input logic [15:0] a, input logic [31:0] wd);
        @(posedge clk);
        #1;
        hsel0  = (d == 0);
        hsel3  = (d == 3);
        htrans = tr;
        hwrite = wr;
        hsize  = sz;
        haddr  = a;
        hwdata = wd;
        @(negedge clk);
    endtask

    // Hold the current address/data while dut3 stretches; counts low cycles
    task automatic count_lows(input logic [1:0] tr, input logic wr, input logic [15:0] a,
                              input logic [31:0] wd, output int n);
        n = 0;
        while (hreadyout3 == 1'b0 && n < 20) begin
            n++;
            cyc(3, tr, wr, SW, a, wd);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; hsel0 = 0; hsel3 = 0; haddr = '0; hwdata = '0; hwrite = 0;
        hsize = SW; htrans = IDL; stall = 0; hburst = '0; hprot = '0; hmastlock = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst rdy0", rdy(0), 1); check("rst rsp0", rsp(0), 0); check("rst dat0", rdat(0), 0);
        check("rst rdy3", rdy(3), 1); check("rst rsp3", rsp(3), 0); check("rst dat3", rdat(3), 0);
        rst_n = 1'b1;

        // Word write then back-to-back read of the same word
        cyc(0, NS, 1, SW, 16'h0010, 32'h0);        check("wr10 rdy", rdy(0), 1);
        cyc(0, NS, 0, SW, 16'h0010, 32'hDEADBEEF); check("rd10 rdy", rdy(0), 1); check("rd10 rsp", rsp(0), 0);
        cyc(0, IDL, 0, SW, 16'h0, 32'h0);          check("rd10 dat", rdat(0), 32'hDEADBEEF);
        check("rd10 rdy2", rdy(0), 1);
        cyc(0, IDL, 0, SW, 16'h0, 32'h0);          check("rd10 hold", rdat(0), 32'hDEADBEEF);

        // Word write, byte write into lane 1, forwarded read, then plain read
        cyc(0, NS, 1, SW, 16'h0020, 32'h0);
        cyc(0, NS, 1, SB, 16'h0021, 32'h11223344);
        cyc(0, NS, 0, SW, 16'h0020, 32'h0000AA00);
        cyc(0, IDL, 0, SW, 16'h0, 32'h0);          check("fwd byte", rdat(0), 32'h1122AA44);
        cyc(0, NS, 0, SW, 16'h0030, 32'h0);        // word 0x30 not yet written: any value
        cyc(0, NS, 1, SW, 16'h0030, 32'h0);
        cyc(0, NS, 1, SH, 16'h0032, 32'hA1B2C3D4);
        cyc(0, NS, 0, SW, 16'h0020, 32'h55667788);
        cyc(0, NS, 0, SW, 16'h0030, 32'h0);        check("rd20", rdat(0), 32'h1122AA44);
        cyc(0, IDL, 0, SW, 16'h0, 32'h0);          check("half hi", rdat(0), 32'h5566C3D4);
        cyc(0, NS, 1, SW, 16'h0000, 32'h0);
        cyc(0, IDL, 0, SW, 16'h0, 32'hCAFEF00D);
        cyc(0, IDL, 0, SW, 16'h0, 32'h0);

        // Misaligned word read: ERR1, ERR2, back to OKAY
        cyc(0, NS, 0, SW, 16'h0402, 32'h0);        check("e1 addr rdy", rdy(0), 1);
        cyc(0, IDL, 0, SW, 16'h0, 32'h0);          check("e1 err1 rdy", rdy(0), 0); check("e1 err1 rsp", rsp(0), 1);
        cyc(0, IDL, 0, SW, 16'h0, 32'h0);          check("e1 err2 rdy", rdy(0), 1); check("e1 err2 rsp", rsp(0), 1);
        check("e1 dat", rdat(0), 0);
        cyc(0, IDL, 0, SW, 16'h0, 32'h0);          check("e1 idle rsp", rsp(0), 0);
        // Out-of-range word write (would alias word 0)
        cyc(0, NS, 1, SW, 16'h0400, 32'h0);
        cyc(0, IDL, 0, SW, 16'h0, 32'hFFFFFFFF);   check("e2 err1 rdy", rdy(0), 0); check("e2 err1 rsp", rsp(0), 1);
        cyc(0, IDL, 0, SW, 16'h0, 32'hFFFFFFFF);   check("e2 err2 rsp", rsp(0), 1);
        cyc(0, IDL, 0, SW, 16'h0, 32'h0);          check("e2 idle rsp", rsp(0), 0);
        // Odd halfword write and oversized transfer
        cyc(0, NS, 1, SH, 16'h0011, 32'h0);
        cyc(0, IDL, 0, SW, 16'h0, 32'hFFFFFFFF);   check("e3 rsp", rsp(0), 1);
        cyc(0, IDL, 0, SW, 16'h0, 32'hFFFFFFFF);
        cyc(0, NS, 0, 3'd3, 16'h0010, 32'h0);
        cyc(0, IDL, 0, SW, 16'h0, 32'h0);          check("e4 rdy", rdy(0), 0); check("e4 rsp", rsp(0), 1);
        cyc(0, IDL, 0, SW, 16'h0, 32'h0);
        cyc(0, NS, 0, SW, 16'h0000, 32'h0);
        cyc(0, NS, 0, SW, 16'h0010, 32'h0);        check("w0 kept", rdat(0), 32'hCAFEF00D);
        cyc(0, IDL, 0, SW, 16'h0, 32'h0);          check("w10 kept", rdat(0), 32'hDEADBEEF);

        // BUSY then IDLE while selected: no access
        cyc(0, BSY, 1, SW, 16'h0010, 32'h0);       check("busy rdy", rdy(0), 1); check("busy rsp", rsp(0), 0);
        cyc(0, IDL, 1, SW, 16'h0010, 32'h12345678); check("idle rdy", rdy(0), 1); check("idle rsp", rsp(0), 0);
        cyc(0, NS, 0, SW, 16'h0020, 32'h12345678);
        cyc(0, NS, 0, SW, 16'h0010, 32'h0);        check("busy rd20", rdat(0), 32'h1122AA44);
        cyc(0, IDL, 0, SW, 16'h0, 32'h0);          check("busy rd10", rdat(0), 32'hDEADBEEF);

        // HREADY held low by another slave: write must not start
        cyc(0, NS, 1, SW, 16'h0020, 32'h0);
        stall = 1'b1;
        cyc(0, IDL, 0, SW, 16'h0, 32'hFFFFFFFF);
        stall = 1'b0;                               check("stall rdy", rdy(0), 1); check("stall rsp", rsp(0), 0);
        cyc(0, IDL, 0, SW, 16'h0, 32'hFFFFFFFF);
        cyc(0, NS, 0, SW, 16'h0020, 32'h0);
        cyc(0, IDL, 0, SW, 16'h0, 32'h0);          check("stall rd20", rdat(0), 32'h1122AA44);

        // Address held through ERR1 (ignored) is taken in ERR2
        cyc(0, NS, 0, SW, 16'h0402, 32'h0);
        cyc(0, NS, 0, SW, 16'h0030, 32'h0);        check("e2acc err1", rdy(0), 0);
        cyc(0, NS, 0, SW, 16'h0030, 32'h0);        check("e2acc err2", rsp(0), 1);
        cyc(0, IDL, 0, SW, 16'h0, 32'h0);          check("e2acc dat", rdat(0), 32'h5566C3D4);
        check("e2acc rsp", rsp(0), 0); check("e2acc rdy", rdy(0), 1);

        // Three wait states: errors take no wait states
        cyc(3, NS, 0, SW, 16'h0041, 32'h0);
        cyc(3, IDL, 0, SW, 16'h0, 32'h0);          check("ws err1 rdy", rdy(3), 0); check("ws err1 rsp", rsp(3), 1);
        cyc(3, IDL, 0, SW, 16'h0, 32'h0);          check("ws err2 rdy", rdy(3), 1); check("ws err2 rsp", rsp(3), 1);
        cyc(3, IDL, 0, SW, 16'h0, 32'h0);          check("ws idle rsp", rsp(3), 0);

        // Write then read with next address taken on the completing edge
        cyc(3, NS, 1, SW, 16'h0040, 32'h0);        check("ws wr addr", rdy(3), 1);
        cyc(3, NS, 0, SW, 16'h0040, 32'h0BADF00D); check("ws hold dat", rdat(3), 0);
        count_lows(NS, 0, 16'h0040, 32'h0BADF00D, lows);
        check("ws wr lows", 32'(lows), 32'd3);     check("ws wr rsp", rsp(3), 0);
        cyc(3, IDL, 0, SW, 16'h0, 32'h0);
        count_lows(IDL, 0, 16'h0, 32'h0, lows);
        check("ws rd lows", 32'(lows), 32'd3);
        check("ws rd dat", rdat(3), 32'h0BADF00D);

        // Reset in the second wait cycle of a write aborts it
        cyc(3, NS, 1, SW, 16'h0040, 32'h0);
        cyc(3, IDL, 0, SW, 16'h0, 32'hFFFFFFFF);
        cyc(3, IDL, 0, SW, 16'h0, 32'hFFFFFFFF);   check("mid rst pre", rdy(3), 0);
        rst_n = 1'b0;
        #1;
        check("mid rst rdy", rdy(3), 1); check("mid rst rsp", rsp(3), 0); check("mid rst dat", rdat(3), 0);
        #2;
        rst_n = 1'b1;
        cyc(3, IDL, 0, SW, 16'h0, 32'h0);          check("post rst rdy", rdy(3), 1);
        cyc(3, NS, 0, SW, 16'h0040, 32'h0);
        cyc(3, IDL, 0, SW, 16'h0, 32'h0);
        count_lows(IDL, 0, 16'h0, 32'h0, lows);
        check("post rst lows", 32'(lows), 32'd3);
        check("post rst kept", rdat(3), 32'h0BADF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
